// File: rtl/keypad_encoder_fifo.sv
// Debounced one-hot keypad encoder feeding a small ready/valid code FIFO.
// Rejects multi-key chords, debounces releases and flags presses dropped on a full queue.
module keypad_encoder_fifo #(
   parameter int NUM_KEYS        = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        enablen,
   input  logic [NUM_KEYS-1:0]         key,
   input  logic                        rd_ready,
   output logic [CODE_W-1:0]           rd_code,
   output logic                        rd_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        press_pulse,
   output logic                        multi_key,
   output logic                        overflow,
   output logic                        key_held
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CYCLES);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [NUM_KEYS-1:0] NO_KEY = {NUM_KEYS{1'b0}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // More than one bit set in the captured key vector.
   function automatic logic multi_hot(input logic [NUM_KEYS-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         multi = multi | (seen & v[i]);
         seen  = seen | v[i];
      end
      return multi;
   endfunction

   function automatic logic [CODE_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
      logic [CODE_W-1:0] code;
      code = {CODE_W{1'b0}};
      for (int i = 0; i < NUM_KEYS; i++) begin
         code = code | (v[i] ? CODE_W'(i) : {CODE_W{1'b0}});
      end
      return code;
   endfunction

   logic [NUM_KEYS-1:0] key_meta_r;
   logic [NUM_KEYS-1:0] ks_r;
   state_t              state_r;
   state_t              state_s;
   logic [CW-1:0]       cnt_r;
   logic [CW-1:0]       cnt_s;
   logic [NUM_KEYS-1:0] cap_r;
   logic [NUM_KEYS-1:0] cap_s;
   logic                accept_s;
   logic                is_multi_s;
   logic                full_s;
   logic                pop_s;
   logic                push_s;
   logic                drop_s;
   logic [CODE_W-1:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0]       wptr_r;
   logic [AW-1:0]       rptr_r;
   logic [AW:0]         count_r;
   logic                press_pulse_r;
   logic                multi_key_r;
   logic                overflow_r;
   logic                key_held_r;

   // Two-flop synchroniser for the asynchronous key levels.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         key_meta_r <= NO_KEY;
         ks_r       <= NO_KEY;
      end else begin
         key_meta_r <= key;
         ks_r       <= key_meta_r;
      end
   end

   // Press/release debounce state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         cap_r   <= NO_KEY;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         cap_r   <= cap_s;
      end
   end

   // Next-state logic; cnt counts identical samples including the first one.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      cap_s    = cap_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if ((ks_r != NO_KEY) && !enablen) begin
               cap_s   = ks_r;
               cnt_s   = CNT_ONE;
               state_s = DEBOUNCE;
            end else begin
               state_s = IDLE;
            end
         end
         DEBOUNCE: begin
            if (enablen || (ks_r == NO_KEY)) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE;
            end else if (ks_r != cap_r) begin
               cap_s = ks_r;
               cnt_s = CNT_ONE;
            end else if ((cnt_r + CNT_ONE) == CNT_DONE) begin
               cnt_s    = CNT_DONE;
               accept_s = 1'b1;
               state_s  = HELD;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         HELD: begin
            if (ks_r == NO_KEY) begin
               cnt_s   = CNT_ONE;
               state_s = RELEASE;
            end else begin
               state_s = HELD;
            end
         end
         RELEASE: begin
            if (ks_r != NO_KEY) begin
               state_s = HELD;
            end else if ((cnt_r + CNT_ONE) == CNT_DONE) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = IDLE;
         end
      endcase
   end

   // A same-cycle pop frees the slot a push into a full queue needs.
   assign is_multi_s = multi_hot(cap_r);
   assign full_s     = (count_r == FULL_COUNT);
   assign pop_s      = rd_valid & rd_ready;
   assign push_s     = accept_s & ~is_multi_s & (~full_s | pop_s);
   assign drop_s     = accept_s & ~is_multi_s & full_s & ~pop_s;

   // Circular code buffer with free-running wrap-around pointers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW + 1){1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {CODE_W{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wptr_r] <= encode(cap_r);
            wptr_r        <= wptr_r + AW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1);
            2'b01:   count_r <= count_r - (AW + 1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered status pulses and flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         press_pulse_r <= 1'b0;
         multi_key_r   <= 1'b0;
         overflow_r    <= 1'b0;
         key_held_r    <= 1'b0;
      end else begin
         press_pulse_r <= push_s;
         multi_key_r   <= accept_s & is_multi_s;
         overflow_r    <= overflow_r | drop_s;
         key_held_r    <= (state_s == HELD);
      end
   end

   assign rd_valid    = (count_r != {(AW + 1){1'b0}});
   assign rd_code     = rd_valid ? mem_r[rptr_r] : {CODE_W{1'b0}};
   assign fifo_count  = count_r;
   assign press_pulse = press_pulse_r;
   assign multi_key   = multi_key_r;
   assign overflow    = overflow_r;
   assign key_held    = key_held_r;

endmodule
